// File: rtl/sram_capture_controller.sv
// One capture/readout cycle of the sample SRAM: init pulse, sampling until trigger plus
// post-trigger delay, then backwards readout to the transmitter. Build option: SRAM_CTRL_KEEP_MASK_EN.
module sram_capture_controller #(
    parameter int CW       = 16,
    parameter int MDW      = 32,
    parameter int READ_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_wr,
    input  logic [3:0]     cfg_groups,
    input  logic [CW-1:0]  cfg_delaycnt,
    input  logic [CW-1:0]  cfg_readcnt,
    input  logic           arm,
    input  logic           abort,
    input  logic           run,
    input  logic           sample_valid,
    input  logic [MDW-1:0] sample_data,
    output logic           mem_cmd_flags,
    output logic [3:0]     mem_cmd_data,
    output logic           mem_write,
    output logic           mem_lastwrite,
    output logic [MDW-1:0] mem_wrdata,
    output logic           mem_rd_ready,
    input  logic [3:0]     mem_rd_keep,
    input  logic [MDW-1:0] mem_rd_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic [MDW-1:0] tx_data,
    output logic [3:0]     tx_keep,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {IDLE, INIT, SAMPLE, DELAY, FETCH, SEND} state_t;

    state_t         state, state_n;
    logic [3:0]     groups_q, groups_n;
    logic [CW-1:0]  delay_q, delay_n;
    logic [CW-1:0]  readcnt_q, readcnt_n;
    logic [CW-1:0]  dcnt_q, dcnt_n;
    logic [CW-1:0]  rcnt_q, rcnt_n;
    logic [CW-1:0]  wcnt_q, wcnt_n;
    logic           tx_valid_n;
    logic [MDW-1:0] tx_data_n;
    logic [3:0]     tx_keep_n;
    logic [MDW-1:0] capture_data;
    logic           writing;
    logic           handshake;

    // Word presented to the transmitter when the read latency has elapsed.
    always_comb begin
        capture_data = mem_rd_data;
`ifdef SRAM_CTRL_KEEP_MASK_EN
        for (int i = 0; i < 4; i++) begin
            if (!mem_rd_keep[i]) capture_data[i*8 +: 8] = 8'h00;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            groups_q  <= 4'hF;
            delay_q   <= '0;
            readcnt_q <= '0;
            dcnt_q    <= '0;
            rcnt_q    <= '0;
            wcnt_q    <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            tx_keep   <= '0;
        end else begin
            state     <= state_n;
            groups_q  <= groups_n;
            delay_q   <= delay_n;
            readcnt_q <= readcnt_n;
            dcnt_q    <= dcnt_n;
            rcnt_q    <= rcnt_n;
            wcnt_q    <= wcnt_n;
            tx_valid  <= tx_valid_n;
            tx_data   <= tx_data_n;
            tx_keep   <= tx_keep_n;
        end
    end

    always_comb begin
        state_n    = state;
        groups_n   = groups_q;
        delay_n    = delay_q;
        readcnt_n  = readcnt_q;
        dcnt_n     = dcnt_q;
        rcnt_n     = rcnt_q;
        wcnt_n     = wcnt_q;
        tx_valid_n = tx_valid;
        tx_data_n  = tx_data;
        tx_keep_n  = tx_keep;

        writing   = (state == SAMPLE || state == DELAY) && !abort;
        handshake = (state == SEND) && tx_valid && tx_ready && !abort;

        mem_cmd_flags = (state == INIT);
        mem_cmd_data  = (state != IDLE) ? groups_q : 4'h0;
        mem_write     = writing && sample_valid;
        mem_lastwrite = writing && (state == DELAY) && sample_valid && (dcnt_q == '0);
        mem_wrdata    = (state == SAMPLE || state == DELAY) ? sample_data : '0;
        mem_rd_ready  = handshake && (rcnt_q != '0);
        done          = handshake && (rcnt_q == '0);
        busy          = (state != IDLE);

        if (abort) begin
            state_n    = IDLE;
            tx_valid_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_wr) begin
                        groups_n  = cfg_groups;
                        delay_n   = cfg_delaycnt;
                        readcnt_n = cfg_readcnt;
                    end
                    if (arm) state_n = INIT;
                end
                INIT: state_n = SAMPLE;
                SAMPLE: begin
                    if (run) begin
                        state_n = DELAY;
                        dcnt_n  = delay_q;
                    end
                end
                DELAY: begin
                    if (sample_valid) begin
                        if (dcnt_q == '0) begin
                            state_n = FETCH;
                            rcnt_n  = readcnt_q;
                            wcnt_n  = CW'(READ_LAT);
                        end else begin
                            dcnt_n = dcnt_q - 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (wcnt_q != '0) begin
                        wcnt_n = wcnt_q - 1'b1;
                    end else begin
                        tx_data_n  = capture_data;
                        tx_keep_n  = mem_rd_keep;
                        tx_valid_n = 1'b1;
                        state_n    = SEND;
                    end
                end
                SEND: begin
                    // The SRAM address already sits on the newest word; step back only between words.
                    if (handshake) begin
                        tx_valid_n = 1'b0;
                        if (rcnt_q == '0) begin
                            state_n = IDLE;
                        end else begin
                            rcnt_n  = rcnt_q - 1'b1;
                            wcnt_n  = CW'(READ_LAT);
                            state_n = FETCH;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_capture_controller.sv
// Directed self-checking bench for sram_capture_controller: capture, stalled readout,
// boundaries, abort, keep masking and ignored inputs.
module tb_sram_capture_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [3:0]  cfg_groups;
    logic [15:0] cfg_delaycnt;
    logic [15:0] cfg_readcnt;
    logic        arm, abort, run, sample_valid;
    logic [31:0] sample_data;
    logic        mem_cmd_flags;
    logic [3:0]  mem_cmd_data;
    logic        mem_write, mem_lastwrite;
    logic [31:0] mem_wrdata;
    logic        mem_rd_ready;
    logic [3:0]  mem_rd_keep;
    logic [31:0] mem_rd_data;
    logic        tx_valid, tx_ready;
    logic [31:0] tx_data;
    logic [3:0]  tx_keep;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

    // SRAM read model: address moves back one word per mem_rd_ready pulse.
    int          rd_steps = 0;
    logic [31:0] rd_base;
    logic        fixed_en;
    logic [31:0] fixed_data;
    logic [3:0]  fixed_keep;

    always @(posedge clk) if (mem_rd_ready) rd_steps <= rd_steps + 1;

    assign mem_rd_data = fixed_en ? fixed_data : (rd_base - 32'(rd_steps));
    assign mem_rd_keep = fixed_en ? fixed_keep : 4'hF;

    always #5 clk = ~clk;

    sram_capture_controller #(.CW(16), .MDW(32), .READ_LAT(2)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_groups(cfg_groups),
        .cfg_delaycnt(cfg_delaycnt), .cfg_readcnt(cfg_readcnt), .arm(arm),
        .abort(abort), .run(run), .sample_valid(sample_valid), .sample_data(sample_data),
        .mem_cmd_flags(mem_cmd_flags), .mem_cmd_data(mem_cmd_data), .mem_write(mem_write),
        .mem_lastwrite(mem_lastwrite), .mem_wrdata(mem_wrdata), .mem_rd_ready(mem_rd_ready),
        .mem_rd_keep(mem_rd_keep), .mem_rd_data(mem_rd_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_keep(tx_keep), .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [3:0] g, input logic [15:0] d, input logic [15:0] r);
        cfg_wr = 1'b1; cfg_groups = g; cfg_delaycnt = d; cfg_readcnt = r;
        tick();
        cfg_wr = 1'b0;
    endtask

    // Arm, pass INIT, land in SAMPLE.
    task automatic arm_to_sample();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
    endtask

    task automatic wait_tx_valid(input string name);
        for (int k = 0; k < 20 && !tx_valid; k++) tick();
        checks++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: tx_valid got %b required 1 within 20 cycles", name, tx_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        #1;
        checks++;
        if ({busy, tx_valid, done, mem_write, mem_lastwrite, mem_cmd_flags, mem_rd_ready} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b required 0000000",
                     {busy, tx_valid, done, mem_write, mem_lastwrite, mem_cmd_flags, mem_rd_ready});
        end
        checks++;
        if ({mem_cmd_data, tx_keep, tx_data, mem_wrdata} !== 72'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: cmd=%h keep=%h data=%h wr=%h required 0",
                     mem_cmd_data, tx_keep, tx_data, mem_wrdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_capture();
        configure(4'hF, 16'd3, 16'd2);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (mem_cmd_flags !== 1'b1 || mem_write !== 1'b0 || mem_cmd_data !== 4'hF) begin
            errors++;
            $display("[TB] FAIL init_pulse: flags=%b write=%b cmd=%h required 1 0 f",
                     mem_cmd_flags, mem_write, mem_cmd_data);
        end
        tick();
        checks++;
        if (mem_cmd_flags !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL init_one_cycle: flags=%b busy=%b required 0 1", mem_cmd_flags, busy);
        end
        for (int s = 1; s <= 10; s++) begin
            sample_valid = 1'b1;
            sample_data  = 32'(s) + 32'h5000_0000;
            run          = (s == 6);
            #1;
            checks++;
            if (mem_write !== 1'b1 || mem_lastwrite !== (s == 10) || mem_wrdata !== 32'(s) + 32'h5000_0000) begin
                errors++;
                $display("[TB] FAIL capture_sample%0d: write=%b last=%b wrdata=%h required 1 %b %h",
                         s, mem_write, mem_lastwrite, mem_wrdata, (s == 10), 32'(s) + 32'h5000_0000);
            end
            tick();
        end
        sample_valid = 1'b0;
        run = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL capture_end: write=%b busy=%b required 0 1", mem_write, busy);
        end
    endtask

    task automatic test_readout_stalls();
        int steps0;
        logic [31:0] exp;
        steps0  = rd_steps;
        rd_base = 32'h1000_000A + 32'(rd_steps);
        for (int w = 0; w < 3; w++) begin
            exp = 32'h1000_000A - 32'(w);
            wait_tx_valid("readout_wait");
            for (int st = 0; st < 3; st++) begin
                checks++;
                if (tx_data !== exp || tx_valid !== 1'b1 || mem_rd_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stall_word%0d_cycle%0d: data=%h valid=%b rd_ready=%b required %h 1 0",
                             w, st, tx_data, tx_valid, mem_rd_ready, exp);
                end
                tick();
            end
            tx_ready = 1'b1;
            #1;
            checks++;
            if (mem_rd_ready !== (w < 2) || done !== (w == 2) || tx_data !== exp) begin
                errors++;
                $display("[TB] FAIL handshake%0d: rd_ready=%b done=%b data=%h required %b %b %h",
                         w, mem_rd_ready, done, tx_data, (w < 2), (w == 2), exp);
            end
            tick();
            tx_ready = 1'b0;
            #1;
            checks++;
            if (mem_rd_ready !== 1'b0 || tx_valid !== 1'b0 || done !== 1'b0 || busy !== (w < 2)) begin
                errors++;
                $display("[TB] FAIL after_handshake%0d: rd_ready=%b valid=%b done=%b busy=%b required 0 0 0 %b",
                         w, mem_rd_ready, tx_valid, done, busy, (w < 2));
            end
        end
        checks++;
        if (rd_steps - steps0 !== 2) begin
            errors++;
            $display("[TB] FAIL rd_ready_count: got %0d required 2", rd_steps - steps0);
        end
    endtask

    task automatic test_boundary();
        int steps0;
        configure(4'h3, 16'd0, 16'd0);
        arm_to_sample();
        steps0  = rd_steps;
        rd_base = 32'h2000_0044 + 32'(rd_steps);
        sample_valid = 1'b1; run = 1'b1; sample_data = 32'h1;
        #1;
        checks++;
        if (mem_write !== 1'b1 || mem_lastwrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bnd_trigger: write=%b last=%b required 1 0", mem_write, mem_lastwrite);
        end
        tick();
        run = 1'b0; sample_valid = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || mem_lastwrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bnd_gap: write=%b last=%b required 0 0", mem_write, mem_lastwrite);
        end
        tick();
        sample_valid = 1'b1; sample_data = 32'h2;
        #1;
        checks++;
        if (mem_write !== 1'b1 || mem_lastwrite !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bnd_last: write=%b last=%b required 1 1", mem_write, mem_lastwrite);
        end
        tick();
        sample_valid = 1'b0;
        wait_tx_valid("bnd_wait");
        tx_ready = 1'b1;
        #1;
        checks++;
        if (tx_data !== 32'h2000_0044 || done !== 1'b1 || mem_rd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bnd_single: data=%h done=%b rd_ready=%b required 20000044 1 0",
                     tx_data, done, mem_rd_ready);
        end
        tick();
        tx_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rd_steps !== steps0) begin
            errors++;
            $display("[TB] FAIL bnd_end: busy=%b rd_steps=%0d required 0 %0d", busy, rd_steps, steps0);
        end
    endtask

    task automatic test_abort();
        configure(4'h3, 16'd5, 16'd0);
        arm_to_sample();
        sample_valid = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        abort = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || mem_lastwrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_write: write=%b last=%b required 0 0", mem_write, mem_lastwrite);
        end
        tick();
        abort = 1'b0; sample_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle: busy=%b valid=%b done=%b required 0 0 0", busy, tx_valid, done);
        end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (mem_cmd_flags !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_rearm: flags=%b busy=%b required 1 1", mem_cmd_flags, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_masking();
        logic [31:0] exp;
`ifdef SRAM_CTRL_KEEP_MASK_EN
        exp = 32'h00BB_CCDD;
`else
        exp = 32'hAABB_CCDD;
`endif
        fixed_en = 1'b1; fixed_data = 32'hAABB_CCDD; fixed_keep = 4'h7;
        configure(4'hF, 16'd0, 16'd0);
        arm_to_sample();
        sample_valid = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        sample_valid = 1'b0;
        wait_tx_valid("mask_wait");
        checks++;
        if (tx_keep !== 4'h7 || tx_data !== exp) begin
            errors++;
            $display("[TB] FAIL mask_word: keep=%h data=%h required 7 %h", tx_keep, tx_data, exp);
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        fixed_en = 1'b0;
    endtask

    task automatic test_ignored_and_reset();
        configure(4'h5, 16'd3, 16'd1);
        arm_to_sample();
        arm = 1'b1; cfg_wr = 1'b1; cfg_groups = 4'hA; cfg_delaycnt = 16'd0; cfg_readcnt = 16'd0;
        tick();
        arm = 1'b0; cfg_wr = 1'b0;
        checks++;
        if (mem_cmd_flags !== 1'b0 || mem_cmd_data !== 4'h5 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ignore_arm_cfg: flags=%b cmd=%h busy=%b required 0 5 1",
                     mem_cmd_flags, mem_cmd_data, busy);
        end
        sample_valid = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        for (int s = 1; s <= 4; s++) begin
            #1;
            checks++;
            if (mem_lastwrite !== (s == 4)) begin
                errors++;
                $display("[TB] FAIL ignore_delay%0d: last=%b required %b", s, mem_lastwrite, (s == 4));
            end
            tick();
        end
        sample_valid = 1'b0;
        rd_base = 32'h3000_0000 + 32'(rd_steps);
        wait_tx_valid("rst_wait1");
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        wait_tx_valid("rst_wait2");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, tx_valid, done, mem_rd_ready, mem_cmd_flags, mem_write} !== 6'b0 ||
            {mem_cmd_data, tx_keep, tx_data} !== 40'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_send: busy=%b valid=%b done=%b cmd=%h keep=%h data=%h required all 0",
                     busy, tx_valid, done, mem_cmd_data, tx_keep, tx_data);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_wr = 1'b0; cfg_groups = 4'h0; cfg_delaycnt = '0; cfg_readcnt = '0;
        arm = 1'b0; abort = 1'b0; run = 1'b0; sample_valid = 1'b0; sample_data = '0;
        tx_ready = 1'b0; rd_base = '0; fixed_en = 1'b0; fixed_data = '0; fixed_keep = 4'hF;
        test_reset();
        test_capture();
        test_readout_stalls();
        test_boundary();
        test_abort();
        test_masking();
        test_ignored_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_capture_controller.md
Name: sram_capture_controller

Overview:
Sequences one capture/readout cycle of the sample SRAM interface.
- Arm: pulses the SRAM init (group configuration), then streams samples into SRAM until a trigger.
- Post-trigger: counts a programmed number of further samples and flags the final write with lastwrite.
- Readout: walks SRAM backwards word by word and forwards words with keep masks to the transmitter over a valid/ready stream.
- Sits between the trigger/sampler front end, the SRAM interface and the transmitter.

Parameters:
CW, 16, width of delay and read counters
MDW, 32, sample/memory data width
READ_LAT, 2, cycles from SRAM address change to valid mem_rd_data/mem_rd_keep

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cfg_wr  input  1  load cfg_* registers; accepted only in IDLE
cfg_groups  input  4  channel-group enables, forwarded as mem_cmd_data
cfg_delaycnt  input  CW  post-trigger sample count D
cfg_readcnt  input  CW  readout word count R (delivers R+1 words)
arm  input  1  start capture; ignored unless IDLE
abort  input  1  return to IDLE from any state
run  input  1  trigger hit
sample_valid  input  1  sample strobe
sample_data  input  MDW  sample
mem_cmd_flags  output  1  one-cycle SRAM init pulse
mem_cmd_data  output  4  latched cfg_groups
mem_write  output  1  SRAM write strobe
mem_lastwrite  output  1  final write flag
mem_wrdata  output  MDW  equals sample_data
mem_rd_ready  output  1  one-cycle step to previous SRAM location
mem_rd_keep  input  4  byte-valid mask from SRAM
mem_rd_data  input  MDW  SRAM read data
tx_valid  output  1  word available
tx_ready  input  1  transmitter accepts
tx_data  output  MDW  held read word
tx_keep  output  4  held byte mask
busy  output  1  state != IDLE
done  output  1  one-cycle pulse on final handshake

Behaviour:
Reset:
- state IDLE.
- All outputs 0.
- Config registers: groups=4'hF, delay=0, readcnt=0.

States: IDLE, INIT, SAMPLE, DELAY, FETCH, SEND.

IDLE
- cfg_wr loads the config registers.
- arm → INIT.

INIT (1 cycle)
- mem_cmd_flags=1.
- Next state SAMPLE.
- Configuration must reach the SRAM before any write; no write occurs in INIT.

SAMPLE
- mem_write=sample_valid; mem_lastwrite=0.
- run=1 → DELAY, dcnt←delay. The trigger-cycle sample is written as a normal write.

DELAY
- mem_write=sample_valid.
- On sample_valid with dcnt==0: mem_lastwrite=1 in the same cycle, then → FETCH with rcnt←readcnt and wait counter←READ_LAT.
- On sample_valid with dcnt!=0: dcnt−1.
- With D=0, the first valid sample after the trigger is the last.

FETCH
- Wait counter counts down to 0.
- At 0: register mem_rd_data/mem_rd_keep into tx_data/tx_keep, set tx_valid=1, → SEND.

SEND
- tx_valid held with data stable until tx_ready.
- On handshake with rcnt==0: done=1, tx_valid←0, → IDLE.
- On handshake with rcnt!=0: mem_rd_ready=1 for exactly one cycle, rcnt−1, tx_valid←0, wait←READ_LAT, → FETCH.
- No rd_ready is ever issued before the first word: lastwrite leaves the SRAM address on the last sample.

Combinational gating:
- mem_write, mem_lastwrite, mem_wrdata and mem_cmd_flags are gated by state.
- mem_write never asserts outside SAMPLE/DELAY.
- mem_rd_ready asserts only on a SEND handshake.

Counters are CW-bit unsigned and never wrap: each decrement is guarded by its !=0 test.

Priority:
- rst, then abort, then normal transitions.
- abort in any state: next cycle IDLE, tx_valid=0, no done.
- Any write in the abort cycle is suppressed (mem_write=0).
- arm while busy and cfg_wr while busy are ignored.
- run outside SAMPLE is ignored.

Optional Feature:
SRAM_CTRL_KEEP_MASK_EN
- Defined: when capturing in FETCH, each tx_data byte i whose mem_rd_keep[i]=0 is forced to 8'h00.
- Undefined: tx_data is the raw mem_rd_data. tx_keep is identical in both builds.

Test Plan:
1. Capture: cfg groups=4'hF, delay=3, readcnt=2; arm; 5 valid samples; run with sample 6; samples 7–10 → mem_cmd_flags one cycle after arm; mem_write on all 10; mem_lastwrite only on sample 10.
2. Readout with stalls: continue case 1 with tx_ready asserted 3 cycles after each tx_valid → exactly 3 words; tx_data stable while stalled; mem_rd_ready pulses 2 times, one cycle each; done on the 3rd handshake; busy=0 next cycle.
3. Boundary: delay=0, readcnt=0 → the first valid sample after the trigger carries lastwrite; a single word is sent with no mem_rd_ready; done.
4. Abort: abort during DELAY with sample_valid=1 → mem_write=0 that cycle; IDLE next; a later arm restarts at INIT.
5. Masking: mem_rd_keep=4'h7, mem_rd_data=32'hAABBCCDD → tx_keep=4'h7; tx_data=32'h00BBCCDD with SRAM_CTRL_KEEP_MASK_EN, 32'hAABBCCDD without.
6. Ignored inputs: arm and cfg_wr during SAMPLE → no state change, config unchanged; synchronous rst mid-SEND → all outputs 0 next cycle.
